led_blink_driver: RTL and testbench

LED_BLINK_DRIVER -- requirements
Module: led_blink_driver

---
 rtl/led_blink_if.sv | 27 ++
 rtl/led_blink_driver.sv | 143 ++++++++++++++
 tb/tb_led_blink_driver.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_if.sv
// Avalon-MM slave bus for the LED blink driver.
// Handshake: a write happens on the clk edge where chipselect=1 and write_n=0;
// the slave never stalls (no waitrequest), so every qualified write is accepted
// on that edge. readdata is combinational from address with zero wait states.
interface led_blink_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_blink_driver.sv
// LED pad driver: registers an upstream LED pattern and drives it to the pads
// with steady, PWM-dimmed or blinking output, controlled over Avalon-MM.
module led_blink_driver #(
    parameter int PRESCALE    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  led_in,
    led_blink_if.slave  bus,
    output logic [7:0]  led_out,
    output logic [1:0]  state_dbg
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_STEADY    = 2'd1,
        ST_BLINK_ON  = 2'd2,
        ST_BLINK_OFF = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_n;
    logic [1:0]    ctrl_q;
    logic [3:0]    bright_q;
    logic [7:0]    led_q;
    logic [7:0]    led_d;
    logic [3:0]    pwm_cnt;
    logic [PW-1:0] presc_cnt;
    logic [BW-1:0] blink_cnt;
    logic          wr;
    logic          ctrl_wr;
    logic          bright_wr;
    logic          pwm_on;
    logic          blinking;
    logic          tick;
    logic          phase_end;
    logic          unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign ctrl_wr      = wr && (bus.address == 2'd0);
    assign bright_wr    = wr && (bus.address == 2'd1);
    assign unused_wdata = ^bus.writedata[31:4];

    assign pwm_on    = (bright_q == 4'd15) || (pwm_cnt < bright_q);
    assign blinking  = (state_q == ST_BLINK_ON) || (state_q == ST_BLINK_OFF);
    assign tick      = blinking && (presc_cnt == PRESC_LAST);
    assign phase_end = tick && (blink_cnt == BLINK_LAST);
    assign state_dbg = state_q;

    // Control registers written from the bus; addresses 2 and 3 are not writable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= 2'b00;
            bright_q <= 4'hF;
        end else begin
            if (ctrl_wr)   ctrl_q   <= bus.writedata[1:0];
            if (bright_wr) bright_q <= bus.writedata[3:0];
        end
    end

    // Input pattern register and free-running 0..14 PWM counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q   <= 8'h00;
            pwm_cnt <= 4'd0;
        end else begin
            led_q   <= led_in;
            pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
        end
    end

    // Tick prescaler and blink counter: run only while blinking, restart on every state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            blink_cnt <= '0;
        end else if ((state_n != state_q) || !blinking) begin
            presc_cnt <= '0;
            blink_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    // State register and registered pad drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            led_out <= 8'h00;
        end else begin
            state_q <= state_n;
            led_out <= led_d;
        end
    end

    // Next state and next pad value; a CTRL write in the phase_end cycle
    // suppresses the phase toggle so the new CTRL value decides the next move.
    always_comb begin
        state_n = state_q;
        led_d   = 8'h00;
        case (state_q)
            ST_OFF: begin
                state_n = ctrl_q[1] ? ST_BLINK_ON : ST_STEADY;
            end
            ST_STEADY: begin
                led_d = led_q & {8{pwm_on}};
                if (ctrl_q[1]) state_n = ST_BLINK_ON;
            end
            ST_BLINK_ON: begin
                led_d = led_q & {8{pwm_on}};
                if (!ctrl_q[1])                  state_n = ST_STEADY;
                else if (phase_end && !ctrl_wr)  state_n = ST_BLINK_OFF;
            end
            ST_BLINK_OFF: begin
                if (!ctrl_q[1])                  state_n = ST_STEADY;
                else if (phase_end && !ctrl_wr)  state_n = ST_BLINK_ON;
            end
            default: state_n = ST_OFF;
        endcase
        if (!ctrl_q[0]) state_n = ST_OFF;
    end

    // Zero-wait-state read mux.
    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            2'd0:    bus.readdata = {30'b0, ctrl_q};
            2'd1:    bus.readdata = {28'b0, bright_q};
            2'd2:    bus.readdata = {22'b0, state_q, led_q};
            default: bus.readdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: directed scenarios plus randomized bus/pattern
// traffic, checked every cycle against a time-based reference model.
module tb_led_blink_driver;

    localparam int PRESCALE    = 4;
    localparam int BLINK_TICKS = 2;
    localparam int PHASE       = PRESCALE * BLINK_TICKS;

    logic       clk;
    logic       reset_n;
    logic [7:0] led_in;
    logic [7:0] led_out;
    logic [1:0] state_dbg;

    led_blink_if bus ();

    led_blink_driver #(
        .PRESCALE    (PRESCALE),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_in    (led_in),
        .bus       (bus),
        .led_out   (led_out),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // State is tracked as "cycles spent in the current state"; a blink phase
    // lasts PRESCALE*BLINK_TICKS cycles and the PWM position is the cycle
    // count since reset modulo 15.
    logic [1:0] m_ctrl;
    logic [3:0] m_bright;
    logic [1:0] m_state;
    logic [7:0] m_led_q;
    logic [7:0] m_led_out;
    int         m_cyc;
    int         m_elapsed;

    task automatic model_reset();
        m_ctrl    = 2'b00;
        m_bright  = 4'hF;
        m_state   = 2'd0;
        m_led_q   = 8'h00;
        m_led_out = 8'h00;
        m_cyc     = 0;
        m_elapsed = 0;
    endtask

    function automatic bit model_phase_end();
        return (m_state >= 2'd2) && ((m_elapsed % PHASE) == PHASE - 1);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {30'b0, m_ctrl};
            2'd1:    return {28'b0, m_bright};
            2'd2:    return {22'b0, m_state, m_led_q};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        bit         wr;
        bit         pe;
        bit         on;
        logic [1:0] sn;
        if (!reset_n) begin
            model_reset();
        end else begin
            wr = bus.chipselect && !bus.write_n;
            pe = model_phase_end() && !(wr && bus.address == 2'd0);
            on = (m_bright == 4'd15) || ((m_cyc % 15) < int'(m_bright));
            m_led_out = (m_state == 2'd1 || m_state == 2'd2) ? (m_led_q & {8{on}}) : 8'h00;
            if (!m_ctrl[0])                          sn = 2'd0;
            else if (m_state <= 2'd1)                sn = m_ctrl[1] ? 2'd2 : 2'd1;
            else if (!m_ctrl[1])                     sn = 2'd1;
            else if (pe)                             sn = (m_state == 2'd2) ? 2'd3 : 2'd2;
            else                                     sn = m_state;
            m_elapsed = (sn != m_state) ? 0 : m_elapsed + 1;
            m_state   = sn;
            if (wr && bus.address == 2'd0) m_ctrl   = bus.writedata[1:0];
            if (wr && bus.address == 2'd1) m_bright = bus.writedata[3:0];
            m_led_q = led_in;
            m_cyc   = m_cyc + 1;
        end
        exp_q.push_back(m_led_out);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("led_out", led_out, exp_q.pop_front());
        check("state", state_dbg, m_state);
        check("readdata", bus.readdata, model_read(bus.address));
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        cycle();
        bus_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   cnt;
        bit   found;
        logic [7:0] exp_led;
        int   op;

        reset_n = 1'b0;
        led_in  = 8'h5A;
        bus_idle();
        model_reset();
        #3;
        check("reset_led", led_out, 8'h00);
        check("reset_state", state_dbg, 2'd0);
        cycle();
        cycle();
        reset_n = 1'b1;

        // Register reads straight after reset, before any further edge.
        for (int a = 0; a < 4; a++) begin
            logic [31:0] exp_rd;
            bus.address = a[1:0];
            #1;
            case (a)
                0:       exp_rd = 32'h0;
                1:       exp_rd = 32'hF;
                default: exp_rd = 32'h0;
            endcase
            check("reset_read", bus.readdata, exp_rd);
            check("reset_led_idle", led_out, 8'h00);
        end
        bus_idle();

        // Steady mode latency.
        led_in = 8'hA5;
        cycle();
        write_reg(2'd0, 32'h1);
        check("steady_not_yet", state_dbg, 2'd0);
        cycle();
        check("steady_state", state_dbg, 2'd1);
        cycle();
        check("steady_a5", led_out, 8'hA5);
        led_in = 8'h3C;
        cycle();
        check("steady_hold_a5", led_out, 8'hA5);
        cycle();
        check("steady_3c", led_out, 8'h3C);

        // Writes to read-only/reserved addresses are ignored.
        write_reg(2'd2, 32'hFFFF_FFFF);
        write_reg(2'd3, 32'hFFFF_FFFF);

        // PWM duty.
        led_in = 8'h01;
        write_reg(2'd1, 32'h5);
        cycle();
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            cnt += int'(led_out[0]);
        end
        check("duty_5", cnt, 5);
        write_reg(2'd1, 32'h0);
        cycle();
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            cnt += int'(led_out[0]);
        end
        check("duty_0", cnt, 0);
        write_reg(2'd1, 32'hF);

        // Blink from OFF.
        led_in = 8'hFF;
        write_reg(2'd0, 32'h0);
        cycle();
        cycle();
        check("off_dark", led_out, 8'h00);
        write_reg(2'd0, 32'h3);
        cycle();
        check("blink_first", led_out, 8'h00);
        for (int i = 1; i <= 32; i++) begin
            cycle();
            exp_led = ((((i - 1) / 8) % 2) == 0) ? 8'hFF : 8'h00;
            check("blink_wave", led_out, exp_led);
        end

        // CTRL write landing on phase_end.
        found = 1'b0;
        for (int i = 0; i < 4 * PHASE && !found; i++) begin
            if (model_phase_end()) found = 1'b1;
            else cycle();
        end
        check("phase_end_found", found, 1'b1);
        write_reg(2'd0, 32'h1);
        cycle();
        check("pe_write_steady", state_dbg, 2'd1);
        write_reg(2'd0, 32'h0);
        cycle();
        cycle();
        check("disable_dark", led_out, 8'h00);

        // Asynchronous reset in the middle of BLINK_ON.
        write_reg(2'd0, 32'h3);
        cycle();
        cycle();
        cycle();
        check("pre_reset_blink_on", state_dbg, 2'd2);
        check("pre_reset_lit", led_out, 8'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_led", led_out, 8'h00);
        check("async_reset_state", state_dbg, 2'd0);
        model_reset();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("post_reset_off", state_dbg, 2'd0);
            check("post_reset_dark", led_out, 8'h00);
        end

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            led_in = 8'($urandom);
            bus_idle();
            op = $urandom_range(0, 39);
            if (op < 2) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'd0;
                bus.writedata  = $urandom;
            end else if (op < 5) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'd1;
                bus.writedata  = $urandom;
            end else if (op < 7) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'($urandom_range(2, 3));
                bus.writedata  = $urandom;
            end else if (op < 12) begin
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b0;
                bus.address    = 2'($urandom_range(0, 1));
                bus.writedata  = $urandom;
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1));
                bus.address    = 2'($urandom_range(0, 3));
            end
            if (i == 350) reset_n = 1'b0;
            if (i == 352) reset_n = 1'b1;
            cycle();
        end

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
